dpram_arbiter: RTL and testbench

DPRAM_ARBITER -- requirements
Module: dpram_arbiter

---
 rtl/dpram_arb_pkg.sv | 15 +
 rtl/dpram_arbiter_if.sv | 42 ++++
 rtl/rr_arb2.sv | 45 ++++
 rtl/dpram_arbiter.sv | 115 +++++++++++
 tb/tb_dpram_arbiter.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dpram_arb_pkg.sv
// Shared constants and FSM state type for the dual-port RAM arbiter.
package dpram_arb_pkg;

    localparam int ADDR_W_DEF  = 5;
    localparam int DATA_W_DEF  = 8;
    localparam int NUM_CLIENTS = 2;
    localparam int MEM_DEPTH   = 16;
    localparam int CNT_W       = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/dpram_arbiter_if.sv
// Client request/grant bus, clear control and RAM port bundle for dpram_arbiter.
interface dpram_arbiter_if
    import dpram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic [NUM_CLIENTS-1:0]        c_wreq;
    logic [NUM_CLIENTS*ADDR_W-1:0] c_waddr;
    logic [NUM_CLIENTS*DATA_W-1:0] c_wdata;
    logic [NUM_CLIENTS-1:0]        c_wgnt;
    logic [NUM_CLIENTS-1:0]        c_rreq;
    logic [NUM_CLIENTS*ADDR_W-1:0] c_raddr;
    logic [NUM_CLIENTS-1:0]        c_rgnt;
    logic [NUM_CLIENTS-1:0]        c_rvalid;
    logic [DATA_W-1:0]             c_rdata;
    logic                          clr_req;
    logic                          clr_busy;
    logic                          clr_done;
    logic                          ram_enb;
    logic                          ram_wr;
    logic                          ram_rd;
    logic [ADDR_W-1:0]             ram_waddr;
    logic [ADDR_W-1:0]             ram_raddr;
    logic [DATA_W-1:0]             ram_wdata;
    logic [DATA_W-1:0]             ram_rdata;

    // Master is the client/RAM environment; slave is the arbiter serving it.
    modport master (
        output c_wreq, c_waddr, c_wdata, c_rreq, c_raddr, clr_req, ram_rdata,
        input  c_wgnt, c_rgnt, c_rvalid, c_rdata, clr_busy, clr_done,
        input  ram_enb, ram_wr, ram_rd, ram_waddr, ram_raddr, ram_wdata
    );

    modport slave (
        input  c_wreq, c_waddr, c_wdata, c_rreq, c_raddr, clr_req, ram_rdata,
        output c_wgnt, c_rgnt, c_rvalid, c_rdata, clr_busy, clr_done,
        output ram_enb, ram_wr, ram_rd, ram_waddr, ram_raddr, ram_wdata
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way combinational arbiter; round-robin pointer when DPRAM_ARB_RR_EN is
// defined, otherwise fixed priority with client 0 winning.
module rr_arb2 (
`ifdef DPRAM_ARB_RR_EN
    input  logic       clk,
`endif
    input  logic       rstn,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

`ifdef DPRAM_ARB_RR_EN
    logic ptr;

    // Pointer names the favoured client and hands priority to the loser.
    always_ff @(posedge clk) begin
        if (!rstn)
            ptr <= 1'b0;
        else if (gnt[0])
            ptr <= 1'b1;
        else if (gnt[1])
            ptr <= 1'b0;
    end

    always_comb begin
        gnt = 2'b00;
        if (rstn && en) begin
            if (req == 2'b11)
                gnt = ptr ? 2'b10 : 2'b01;
            else
                gnt = req;
        end
    end
`else
    always_comb begin
        gnt = 2'b00;
        if (rstn && en) begin
            gnt[0] = req[0];
            gnt[1] = req[1] & ~req[0];
        end
    end
`endif

endmodule

// File: rtl/dpram_arbiter.sv
// Two-client arbiter in front of a dual-port RAM with a hardware clear sweep.
// Macro DPRAM_ARB_RR_EN selects round-robin instead of fixed priority.
module dpram_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input logic             clk,
    input logic             rstn,
    dpram_arbiter_if.slave  bus
);

    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt;
    logic                   last;
    logic                   done_q;
    logic [NUM_CLIENTS-1:0] rvalid_q;
    logic [NUM_CLIENTS-1:0] wgnt, rgnt;
    logic                   wr_en;
    logic                   wr, rd;
    logic [ADDR_W-1:0]      waddr, raddr;
    logic [DATA_W-1:0]      wdata;

    assign wr_en = (state == IDLE);
    assign last  = (state == CLEAR) && (cnt == CNT_W'(MEM_DEPTH - 1));

    rr_arb2 u_warb (
`ifdef DPRAM_ARB_RR_EN
        .clk  (clk),
`endif
        .rstn (rstn),
        .en   (wr_en),
        .req  (bus.c_wreq),
        .gnt  (wgnt)
    );

    rr_arb2 u_rarb (
`ifdef DPRAM_ARB_RR_EN
        .clk  (clk),
`endif
        .rstn (rstn),
        .en   (1'b1),
        .req  (bus.c_rreq),
        .gnt  (rgnt)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            done_q   <= 1'b0;
            rvalid_q <= '0;
        end else begin
            state    <= state_n;
            cnt      <= (state == CLEAR) ? cnt + CNT_W'(1) : '0;
            done_q   <= last;
            rvalid_q <= rgnt;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.clr_req) state_n = CLEAR;
            CLEAR:   if (last)        state_n = IDLE;
            default:                  state_n = IDLE;
        endcase
    end

    // The clear sweep owns the write port; client writes are held off.
    always_comb begin
        wr    = 1'b0;
        waddr = '0;
        wdata = '0;
        if (rstn && state == CLEAR) begin
            wr    = 1'b1;
            waddr = ADDR_W'(cnt);
        end else if (wgnt[1]) begin
            wr    = 1'b1;
            waddr = bus.c_waddr[ADDR_W +: ADDR_W];
            wdata = bus.c_wdata[DATA_W +: DATA_W];
        end else if (wgnt[0]) begin
            wr    = 1'b1;
            waddr = bus.c_waddr[0 +: ADDR_W];
            wdata = bus.c_wdata[0 +: DATA_W];
        end
    end

    always_comb begin
        rd    = 1'b0;
        raddr = '0;
        if (rgnt[1]) begin
            rd    = 1'b1;
            raddr = bus.c_raddr[ADDR_W +: ADDR_W];
        end else if (rgnt[0]) begin
            rd    = 1'b1;
            raddr = bus.c_raddr[0 +: ADDR_W];
        end
    end

    assign bus.c_wgnt    = wgnt;
    assign bus.c_rgnt    = rgnt;
    assign bus.c_rvalid  = rvalid_q;
    assign bus.c_rdata   = bus.ram_rdata;
    assign bus.clr_busy  = rstn && (state == CLEAR);
    assign bus.clr_done  = done_q;
    assign bus.ram_wr    = wr;
    assign bus.ram_rd    = rd;
    assign bus.ram_enb   = wr | rd;
    assign bus.ram_waddr = waddr;
    assign bus.ram_raddr = raddr;
    assign bus.ram_wdata = wdata;

endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed testbench for dpram_arbiter with a behavioural dual-port RAM model.
module tb_dpram_arbiter;

    logic clk = 1'b0;
    logic rstn;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    dpram_arbiter_if #(.ADDR_W(5), .DATA_W(8)) bus ();

    dpram_arbiter #(.ADDR_W(5), .DATA_W(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // Sync RAM, 16 entries, registered read with write-to-read forwarding.
    logic [7:0] mem [16];
    logic [7:0] rdata_q;
    assign bus.ram_rdata = rdata_q;

    always @(posedge clk) begin
        if (bus.ram_enb) begin
            if (bus.ram_wr)
                mem[bus.ram_waddr[3:0]] <= bus.ram_wdata;
            if (bus.ram_rd)
                rdata_q <= (bus.ram_wr && bus.ram_waddr[3:0] == bus.ram_raddr[3:0])
                           ? bus.ram_wdata : mem[bus.ram_raddr[3:0]];
        end
    end

    task automatic idle_inputs();
        bus.c_wreq  = 2'b00;
        bus.c_waddr = '0;
        bus.c_wdata = '0;
        bus.c_rreq  = 2'b00;
        bus.c_raddr = '0;
        bus.clr_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic fill_mem(input logic [7:0] d);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.c_wreq  = 2'b01;
            bus.c_waddr = {5'd0, 5'(i)};
            bus.c_wdata = {8'h00, d};
        end
        @(negedge clk);
        bus.c_wreq = 2'b00;
    endtask

    task automatic test_reset();
        rstn        = 1'b0;
        bus.c_wreq  = 2'b11;
        bus.c_rreq  = 2'b11;
        bus.c_waddr = {5'd4, 5'd9};
        bus.c_raddr = {5'd4, 5'd9};
        bus.c_wdata = 16'h1234;
        bus.clr_req = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (bus.c_wgnt !== 2'b00) begin errors++; $display("FAIL rst_wgnt: got %b expected 00", bus.c_wgnt); end
        checks++; if (bus.c_rgnt !== 2'b00) begin errors++; $display("FAIL rst_rgnt: got %b expected 00", bus.c_rgnt); end
        checks++; if (bus.ram_enb !== 1'b0) begin errors++; $display("FAIL rst_enb: got %b expected 0", bus.ram_enb); end
        checks++; if (bus.ram_wr !== 1'b0) begin errors++; $display("FAIL rst_wr: got %b expected 0", bus.ram_wr); end
        checks++; if (bus.ram_waddr !== 5'd0) begin errors++; $display("FAIL rst_waddr: got %h expected 0", bus.ram_waddr); end
        checks++; if (bus.c_rvalid !== 2'b00) begin errors++; $display("FAIL rst_rvalid: got %b expected 00", bus.c_rvalid); end
        checks++; if (bus.clr_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.clr_busy); end
        checks++; if (bus.clr_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", bus.clr_done); end
        idle_inputs();
        rstn = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (bus.clr_busy !== 1'b0) begin errors++; $display("FAIL rst_release_busy: got %b expected 0", bus.clr_busy); end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        bus.c_wreq  = 2'b01;
        bus.c_waddr = {5'd0, 5'd3};
        bus.c_wdata = {8'h00, 8'hA5};
        #1;
        checks++; if (bus.c_wgnt !== 2'b01) begin errors++; $display("FAIL wr_gnt: got %b expected 01", bus.c_wgnt); end
        checks++; if (bus.ram_wr !== 1'b1) begin errors++; $display("FAIL wr_ram_wr: got %b expected 1", bus.ram_wr); end
        checks++; if (bus.ram_waddr !== 5'd3) begin errors++; $display("FAIL wr_addr: got %h expected 03", bus.ram_waddr); end
        checks++; if (bus.ram_wdata !== 8'hA5) begin errors++; $display("FAIL wr_data: got %h expected a5", bus.ram_wdata); end
        @(negedge clk);
        bus.c_wreq  = 2'b00;
        bus.c_rreq  = 2'b10;
        bus.c_raddr = {5'd3, 5'd0};
        #1;
        checks++; if (bus.c_rgnt !== 2'b10) begin errors++; $display("FAIL rd_gnt: got %b expected 10", bus.c_rgnt); end
        checks++; if (bus.ram_raddr !== 5'd3) begin errors++; $display("FAIL rd_addr: got %h expected 03", bus.ram_raddr); end
        checks++; if (bus.ram_wr !== 1'b0) begin errors++; $display("FAIL rd_no_wr: got %b expected 0", bus.ram_wr); end
        @(negedge clk);
        bus.c_rreq = 2'b00;
        #1;
        checks++; if (bus.c_rvalid !== 2'b10) begin errors++; $display("FAIL rd_valid: got %b expected 10", bus.c_rvalid); end
        checks++; if (bus.c_rdata !== 8'hA5) begin errors++; $display("FAIL rd_data: got %h expected a5", bus.c_rdata); end
        @(negedge clk);
        #1;
        checks++; if (bus.c_rvalid !== 2'b00) begin errors++; $display("FAIL rd_valid_drop: got %b expected 00", bus.c_rvalid); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_g;
        logic [1:0] prev_g;
        do_reset();
        @(negedge clk);
        bus.c_wreq  = 2'b11;
        bus.c_waddr = {5'd2, 5'd1};
        bus.c_wdata = {8'h22, 8'h11};
        for (int k = 0; k < 6; k++) begin
            #1;
`ifdef DPRAM_ARB_RR_EN
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            checks++; if (bus.c_wgnt !== exp_g) begin errors++; $display("FAIL b2b_wgnt[%0d]: got %b expected %b", k, bus.c_wgnt, exp_g); end
            checks++; if (bus.ram_waddr !== ((exp_g == 2'b01) ? 5'd1 : 5'd2)) begin errors++; $display("FAIL b2b_waddr[%0d]: got %h grant %b", k, bus.ram_waddr, exp_g); end
            @(negedge clk);
        end
        bus.c_wreq  = 2'b00;
        bus.c_rreq  = 2'b11;
        bus.c_raddr = {5'd2, 5'd1};
        prev_g      = 2'b00;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) bus.c_rreq = 2'b00;
            #1;
`ifdef DPRAM_ARB_RR_EN
            exp_g = (k == 4) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10);
`else
            exp_g = (k == 4) ? 2'b00 : 2'b01;
`endif
            checks++; if (bus.c_rgnt !== exp_g) begin errors++; $display("FAIL b2b_rgnt[%0d]: got %b expected %b", k, bus.c_rgnt, exp_g); end
            if (k > 0) begin
                checks++; if (bus.c_rvalid !== prev_g) begin errors++; $display("FAIL b2b_rvalid[%0d]: got %b expected %b", k, bus.c_rvalid, prev_g); end
                checks++; if (bus.c_rdata !== ((prev_g == 2'b01) ? 8'h11 : 8'h22)) begin errors++; $display("FAIL b2b_rdata[%0d]: got %h prev grant %b", k, bus.c_rdata, prev_g); end
            end
            prev_g = exp_g;
            @(negedge clk);
        end
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        bus.c_wreq  = 2'b01;
        bus.c_waddr = {5'd0, 5'd7};
        bus.c_wdata = {8'h00, 8'h3C};
        bus.c_rreq  = 2'b01;
        bus.c_raddr = {5'd0, 5'd7};
        #1;
        checks++; if (bus.c_wgnt !== 2'b01) begin errors++; $display("FAIL fwd_wgnt: got %b expected 01", bus.c_wgnt); end
        checks++; if (bus.c_rgnt !== 2'b01) begin errors++; $display("FAIL fwd_rgnt: got %b expected 01", bus.c_rgnt); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (bus.c_rvalid !== 2'b01) begin errors++; $display("FAIL fwd_rvalid: got %b expected 01", bus.c_rvalid); end
        checks++; if (bus.c_rdata !== 8'h3C) begin errors++; $display("FAIL fwd_rdata: got %h expected 3c", bus.c_rdata); end
    endtask

    task automatic test_clear();
        fill_mem(8'hFF);
        bus.clr_req = 1'b1;
        #1;
        checks++; if (bus.clr_busy !== 1'b0) begin errors++; $display("FAIL clr_pre_busy: got %b expected 0", bus.clr_busy); end
        @(negedge clk);
        bus.clr_req = 1'b0;
        bus.c_wreq  = 2'b01;
        bus.c_waddr = {5'd0, 5'd5};
        bus.c_wdata = {8'h00, 8'h77};
        for (int k = 0; k < 16; k++) begin
            if (k == 3) begin bus.c_rreq = 2'b10; bus.c_raddr = {5'd15, 5'd0}; end
            if (k == 4) bus.c_rreq = 2'b00;
            if (k == 8) bus.clr_req = 1'b1;
            if (k == 9) bus.clr_req = 1'b0;
            if (k == 15) bus.c_wreq = 2'b00;
            #1;
            checks++; if (bus.clr_busy !== 1'b1) begin errors++; $display("FAIL clr_busy[%0d]: got %b expected 1", k, bus.clr_busy); end
            checks++; if (bus.c_wgnt !== 2'b00) begin errors++; $display("FAIL clr_wgnt[%0d]: got %b expected 00", k, bus.c_wgnt); end
            checks++; if (bus.ram_wr !== 1'b1 || bus.ram_waddr !== 5'(k) || bus.ram_wdata !== 8'h00) begin errors++; $display("FAIL clr_sweep[%0d]: got wr=%b addr=%h data=%h expected wr=1 addr=%h data=00", k, bus.ram_wr, bus.ram_waddr, bus.ram_wdata, k); end
            checks++; if (bus.clr_done !== 1'b0) begin errors++; $display("FAIL clr_done_early[%0d]: got %b expected 0", k, bus.clr_done); end
            if (k == 3) begin
                checks++; if (bus.c_rgnt !== 2'b10) begin errors++; $display("FAIL clr_rgnt: got %b expected 10", bus.c_rgnt); end
            end
            if (k == 4) begin
                checks++; if (bus.c_rvalid !== 2'b10 || bus.c_rdata !== 8'hFF) begin errors++; $display("FAIL clr_read: got valid=%b data=%h expected valid=10 data=ff", bus.c_rvalid, bus.c_rdata); end
            end
            @(negedge clk);
        end
        #1;
        checks++; if (bus.clr_done !== 1'b1) begin errors++; $display("FAIL clr_done: got %b expected 1", bus.clr_done); end
        checks++; if (bus.clr_busy !== 1'b0) begin errors++; $display("FAIL clr_busy_end: got %b expected 0", bus.clr_busy); end
        checks++; if (bus.ram_wr !== 1'b0) begin errors++; $display("FAIL clr_wr_end: got %b expected 0", bus.ram_wr); end
        @(negedge clk);
        #1;
        checks++; if (bus.clr_done !== 1'b0) begin errors++; $display("FAIL clr_done_pulse: got %b expected 0", bus.clr_done); end
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            if (i < 16) begin bus.c_rreq = 2'b01; bus.c_raddr = {5'd0, 5'(i)}; end
            else bus.c_rreq = 2'b00;
            #1;
            if (i > 0) begin
                checks++; if (bus.c_rvalid !== 2'b01 || bus.c_rdata !== 8'h00) begin errors++; $display("FAIL clr_readback[%0d]: got valid=%b data=%h expected valid=01 data=00", i - 1, bus.c_rvalid, bus.c_rdata); end
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        fill_mem(8'hFF);
        bus.clr_req = 1'b1;
        @(negedge clk);
        bus.clr_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 7) begin bus.c_rreq = 2'b01; bus.c_raddr = {5'd0, 5'd12}; end
            @(negedge clk);
        end
        bus.c_rreq = 2'b00;
        #1;
        checks++; if (bus.ram_waddr !== 5'd8 || bus.clr_busy !== 1'b1) begin errors++; $display("FAIL mid_point: got addr=%h busy=%b expected addr=08 busy=1", bus.ram_waddr, bus.clr_busy); end
        checks++; if (bus.c_rvalid !== 2'b01) begin errors++; $display("FAIL mid_rvalid_pre: got %b expected 01", bus.c_rvalid); end
        rstn = 1'b0;
        #1;
        checks++; if (bus.ram_wr !== 1'b0) begin errors++; $display("FAIL mid_rst_wr: got %b expected 0", bus.ram_wr); end
        @(negedge clk);
        #1;
        checks++; if (bus.clr_busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", bus.clr_busy); end
        checks++; if (bus.clr_done !== 1'b0) begin errors++; $display("FAIL mid_done: got %b expected 0", bus.clr_done); end
        checks++; if (bus.c_rvalid !== 2'b00) begin errors++; $display("FAIL mid_rvalid: got %b expected 00", bus.c_rvalid); end
        rstn = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            checks++; if (bus.clr_done !== 1'b0 || bus.clr_busy !== 1'b0) begin errors++; $display("FAIL mid_after[%0d]: got done=%b busy=%b expected 0 0", k, bus.clr_done, bus.clr_busy); end
        end
        @(negedge clk);
        bus.c_rreq  = 2'b01;
        bus.c_raddr = {5'd0, 5'd7};
        @(negedge clk);
        bus.c_raddr = {5'd0, 5'd8};
        #1;
        checks++; if (bus.c_rdata !== 8'h00) begin errors++; $display("FAIL mid_addr7: got %h expected 00", bus.c_rdata); end
        @(negedge clk);
        bus.c_rreq = 2'b00;
        #1;
        checks++; if (bus.c_rdata !== 8'hFF) begin errors++; $display("FAIL mid_addr8: got %h expected ff", bus.c_rdata); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_write_read();
        test_back_to_back();
        test_same_cycle();
        test_clear();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

endmodule
